rs232_fifo_transmitter: RTL and testbench

//  Consumer end of the byte fifo: pops words one at a time via the fifo's pop/out_data/popped_last

---
 rtl/rs232_pkg.sv | 28 ++
 rtl/rs232_baud_generator.sv | 29 ++
 rtl/rs232_fifo_transmitter.sv | 206 ++++++++++++++++++++
 tb/tb_rs232_fifo_transmitter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared definitions for the RS232 fifo transmitter: FSM encoding, parity modes,
// fifo handshake timing and the baud divisor helper.
package rs232_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_POP_REQ,
    ST_POP_WAIT,
    ST_START_BIT,
    ST_DATA_BITS,
    ST_PARITY_BIT,
    ST_STOP_BIT,
    ST_FINISH,
    ST_ABORT
  } tx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int FIFO_POP_LATENCY  = 3;
  localparam int FIFO_READY_SETTLE = 2;

  function automatic int baud_divisor(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/rs232_baud_generator.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and pulses bit_tick on the last count.
// restart holds the counter at zero so a new bit starts on a clean period.
module rs232_baud_generator #(
  parameter int BAUD_DIV = 434
) (
  input  logic clk,
  input  logic clear_n,
  input  logic restart,
  output logic bit_tick
);

  localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = !restart && (cnt == LAST);

endmodule

// File: rtl/rs232_fifo_transmitter.sv
// Drains the TX byte fifo through its pop handshake and serialises each word as
// an RS232 frame on a registered tx line.
module rs232_fifo_transmitter
  import rs232_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY      = PARITY_NONE,
  parameter int STOP_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic                  start,
  input  logic                  fifo_ready,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  output logic                  tx,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [15:0]           byte_count
);

  localparam int BAUD_DIV = baud_divisor(CLK_FREQ_HZ, BAUD_RATE);

  tx_state_e             state, state_nx;
  logic [DATA_WIDTH-1:0] shift_reg, shift_nx;
  logic                  parity_bit, parity_nx;
  logic [3:0]            bit_cnt, bit_nx;
  logic [1:0]            wait_cnt, wait_nx;
  logic                  stop_cnt, stop_nx;
  logic [1:0]            ready_age;
  logic                  ready_settled;
  logic                  tx_nx, pop_nx, busy_nx, done_nx, aborted_nx;
  logic [15:0]           count_nx;
  logic                  in_frame, bit_tick;

  function automatic logic frame_parity(input logic [DATA_WIDTH-1:0] d);
    return (PARITY == PARITY_ODD) ? ~^d : ^d;
  endfunction

  assign in_frame = (state == ST_START_BIT) || (state == ST_DATA_BITS) ||
                    (state == ST_PARITY_BIT) || (state == ST_STOP_BIT);

  rs232_baud_generator #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk      (clk),
    .clear_n  (clear_n),
    .restart  (!in_frame),
    .bit_tick (bit_tick)
  );

  // The fifo needs a few cycles after fifo_ready rises before it accepts a pop.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      ready_age <= '0;
    end else if (!fifo_ready) begin
      ready_age <= '0;
    end else if (!ready_settled) begin
      ready_age <= ready_age + 1'b1;
    end
  end

  assign ready_settled = (ready_age == 2'(FIFO_READY_SETTLE));

  always_comb begin
    state_nx   = state;
    shift_nx   = shift_reg;
    parity_nx  = parity_bit;
    bit_nx     = bit_cnt;
    wait_nx    = wait_cnt;
    stop_nx    = stop_cnt;
    pop_nx     = 1'b0;
    busy_nx    = busy;
    done_nx    = 1'b0;
    aborted_nx = 1'b0;
    count_nx   = byte_count;
    tx_nx      = 1'b1;

    case (state)
      ST_IDLE: begin
        if (start) begin
          if (fifo_ready) begin
            state_nx = ST_POP_REQ;
            busy_nx  = 1'b1;
            count_nx = '0;
          end else begin
            aborted_nx = 1'b1;
          end
        end
      end
      ST_POP_REQ: begin
        if (!fifo_ready) begin
          state_nx = ST_ABORT;
        end else if (ready_settled) begin
          pop_nx   = 1'b1;
          wait_nx  = '0;
          state_nx = ST_POP_WAIT;
        end
      end
      ST_POP_WAIT: begin
        if (wait_cnt == 2'(FIFO_POP_LATENCY - 1)) begin
          if (!fifo_ready) begin
            state_nx = ST_ABORT;
          end else if (fifo_empty) begin
            state_nx = ST_FINISH;
          end else begin
            shift_nx  = fifo_data;
            parity_nx = frame_parity(fifo_data);
            bit_nx    = '0;
            state_nx  = ST_START_BIT;
          end
        end else begin
          wait_nx = wait_cnt + 1'b1;
        end
      end
      ST_START_BIT: begin
        if (bit_tick) state_nx = ST_DATA_BITS;
      end
      ST_DATA_BITS: begin
        if (bit_tick) begin
          if (bit_cnt == 4'(DATA_WIDTH - 1)) begin
            if (PARITY != PARITY_NONE) begin
              state_nx = ST_PARITY_BIT;
            end else begin
              state_nx = ST_STOP_BIT;
              stop_nx  = 1'b0;
              count_nx = byte_count + 1'b1;
            end
          end else begin
            bit_nx   = bit_cnt + 1'b1;
            shift_nx = shift_reg >> 1;
          end
        end
      end
      ST_PARITY_BIT: begin
        if (bit_tick) begin
          state_nx = ST_STOP_BIT;
          stop_nx  = 1'b0;
          count_nx = byte_count + 1'b1;
        end
      end
      ST_STOP_BIT: begin
        if (bit_tick) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            state_nx = fifo_ready ? ST_POP_REQ : ST_ABORT;
          end else begin
            stop_nx = 1'b1;
          end
        end
      end
      ST_FINISH: begin
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = ST_IDLE;
      end
      ST_ABORT: begin
        aborted_nx = 1'b1;
        busy_nx    = 1'b0;
        state_nx   = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase

    // tx is registered from the next state so the line changes exactly on bit boundaries.
    case (state_nx)
      ST_START_BIT:  tx_nx = 1'b0;
      ST_DATA_BITS:  tx_nx = shift_nx[0];
      ST_PARITY_BIT: tx_nx = parity_nx;
      default:       tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state      <= ST_IDLE;
      tx         <= 1'b1;
      fifo_pop   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      byte_count <= '0;
      bit_cnt    <= '0;
      wait_cnt   <= '0;
      stop_cnt   <= 1'b0;
    end else begin
      state      <= state_nx;
      tx         <= tx_nx;
      fifo_pop   <= pop_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      aborted    <= aborted_nx;
      byte_count <= count_nx;
      bit_cnt    <= bit_nx;
      wait_cnt   <= wait_nx;
      stop_cnt   <= stop_nx;
    end
  end

  always_ff @(posedge clk) begin
    shift_reg  <= shift_nx;
    parity_bit <= parity_nx;
  end

endmodule

// File: tb/tb_rs232_fifo_transmitter.sv
// Bench for rs232_fifo_transmitter: three configurations, a behavioural fifo,
// and a line monitor that decodes every frame bit against the pushed bytes.
module tb_rs232_fifo_transmitter;

  localparam int DIV = 434;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       start      [3];
  logic       fifo_ready [3];
  logic [7:0] fifo_data  [3];
  logic       fifo_empty [3];
  logic       fifo_pop   [3];
  logic       tx         [3];
  logic       busy       [3];
  logic       done       [3];
  logic       aborted    [3];
  logic [15:0] byte_count [3];

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [3][64];
  int wr_ptr [3];
  int rd_ptr [3];
  int exp_ptr [3];

  int frames [3];
  int done_cnt [3];
  int abort_cnt [3];
  int pop_cnt [3];

  always #10 clk = ~clk;

  rs232_fifo_transmitter #(.CLK_FREQ_HZ(50000000), .BAUD_RATE(115200), .DATA_WIDTH(8),
                           .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .clear_n(clear_n), .start(start[0]), .fifo_ready(fifo_ready[0]),
    .fifo_data(fifo_data[0]), .fifo_empty(fifo_empty[0]), .fifo_pop(fifo_pop[0]),
    .tx(tx[0]), .busy(busy[0]), .done(done[0]), .aborted(aborted[0]),
    .byte_count(byte_count[0]));

  rs232_fifo_transmitter #(.CLK_FREQ_HZ(50000000), .BAUD_RATE(115200), .DATA_WIDTH(8),
                           .PARITY(2), .STOP_BITS(2)) dut1 (
    .clk(clk), .clear_n(clear_n), .start(start[1]), .fifo_ready(fifo_ready[1]),
    .fifo_data(fifo_data[1]), .fifo_empty(fifo_empty[1]), .fifo_pop(fifo_pop[1]),
    .tx(tx[1]), .busy(busy[1]), .done(done[1]), .aborted(aborted[1]),
    .byte_count(byte_count[1]));

  rs232_fifo_transmitter #(.CLK_FREQ_HZ(50000000), .BAUD_RATE(115200), .DATA_WIDTH(8),
                           .PARITY(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .clear_n(clear_n), .start(start[2]), .fifo_ready(fifo_ready[2]),
    .fifo_data(fifo_data[2]), .fifo_empty(fifo_empty[2]), .fifo_pop(fifo_pop[2]),
    .tx(tx[2]), .busy(busy[2]), .done(done[2]), .aborted(aborted[2]),
    .byte_count(byte_count[2]));

  function automatic int par_of(input int k);
    return (k == 1) ? 2 : (k == 2) ? 1 : 0;
  endfunction

  function automatic int stops_of(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  // Transmitted bit i of a frame sits at index i; unused upper positions stay idle-high.
  function automatic logic [11:0] build_frame(input logic [7:0] d, input int par);
    logic [11:0] f;
    int ones;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    ones = $countones(d);
    if (par == 2) f[9] = (ones % 2 == 1);
    if (par == 1) f[9] = (ones % 2 == 0);
    return f;
  endfunction

  function automatic int frame_len(input int k);
    return 1 + 8 + ((par_of(k) != 0) ? 1 : 0) + stops_of(k);
  endfunction

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Behavioural fifo: a pop seen at a rising edge presents the head word at that edge.
  initial begin
    for (int k = 0; k < 3; k++) begin
      fifo_empty[k] = 1'b1;
      fifo_data[k]  = 8'h00;
      rd_ptr[k]     = 0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        if (fifo_pop[k]) begin
          if (rd_ptr[k] == wr_ptr[k]) begin
            fifo_empty[k] <= 1'b1;
          end else begin
            fifo_data[k]  <= mem[k][rd_ptr[k] % 64];
            fifo_empty[k] <= 1'b0;
            rd_ptr[k]++;
          end
        end
      end
    end
  end

  // Line monitor: every in-frame cycle is compared with the expected frame bit.
  initial begin
    int          mf_t [3];
    bit          mf_in [3];
    bit          mf_skip [3];
    logic [11:0] mf_bits [3];
    int          idle_run [3];
    bit          gap_armed [3];
    int          pop_gap [3];
    logic        prev_pop [3];
    logic        prev_done [3];
    logic        prev_abort [3];
    for (int k = 0; k < 3; k++) begin
      mf_t[k] = 0; mf_in[k] = 0; mf_skip[k] = 0; mf_bits[k] = '1;
      idle_run[k] = 0; gap_armed[k] = 0; pop_gap[k] = 100;
      prev_pop[k] = 0; prev_done[k] = 0; prev_abort[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!clear_n) begin
          mf_in[k]     = 1'b0;
          gap_armed[k] = 1'b0;
        end else begin
          if (!mf_in[k] && tx[k] == 1'b0) begin
            check(wr_ptr[k] != exp_ptr[k], "frame_expected", wr_ptr[k] - exp_ptr[k], 1);
            check(busy[k] == 1'b1, "frame_while_busy", busy[k], 1);
            mf_skip[k] = (wr_ptr[k] == exp_ptr[k]);
            if (!mf_skip[k]) begin
              mf_bits[k] = build_frame(mem[k][exp_ptr[k] % 64], par_of(k));
              exp_ptr[k]++;
            end
            if (gap_armed[k]) check(idle_run[k] <= 6, "frame_gap", idle_run[k], 6);
            gap_armed[k] = 1'b0;
            mf_in[k] = 1'b1;
            mf_t[k]  = 0;
          end
          if (mf_in[k]) begin
            if (!mf_skip[k])
              check(tx[k] == mf_bits[k][mf_t[k] / DIV], "tx_bit", tx[k], mf_bits[k][mf_t[k] / DIV]);
            mf_t[k]++;
            if (mf_t[k] == frame_len(k) * DIV) begin
              mf_in[k]     = 1'b0;
              frames[k]++;
              gap_armed[k] = 1'b1;
              idle_run[k]  = 0;
            end
          end else begin
            if (done[k] && gap_armed[k]) check(idle_run[k] <= 6, "done_after_stop", idle_run[k], 6);
            idle_run[k]++;
          end
          if (done[k]) begin
            done_cnt[k]++;
            gap_armed[k] = 1'b0;
            check(!prev_done[k], "done_width", 2, 1);
          end
          if (aborted[k]) begin
            abort_cnt[k]++;
            gap_armed[k] = 1'b0;
            check(!prev_abort[k], "aborted_width", 2, 1);
          end
          if (fifo_pop[k]) begin
            pop_cnt[k]++;
            check(!prev_pop[k], "pop_width", 2, 1);
            check(pop_gap[k] >= 4, "pop_spacing", pop_gap[k], 4);
            pop_gap[k] = 0;
          end else begin
            pop_gap[k]++;
          end
        end
        prev_pop[k]   = fifo_pop[k];
        prev_done[k]  = done[k];
        prev_abort[k] = aborted[k];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [7:0] b);
    mem[k][wr_ptr[k] % 64] = b;
    wr_ptr[k]++;
  endtask

  task automatic pulse(input int k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  function automatic bit sig(input int k, input int sel);
    case (sel)
      0:       return done[k];
      1:       return aborted[k];
      default: return !tx[k];
    endcase
  endfunction

  task automatic wait_sig(input int k, input int sel, input int budget, input string name,
                          output int n);
    n = 0;
    while (!sig(k, sel) && n < budget) begin
      tick();
      n++;
    end
    check(sig(k, sel), name, n, budget);
  endtask

  initial begin
    int n, f0, d0, p0, a0;
    clear_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0; fifo_ready[k] = 1'b1;
      wr_ptr[k] = 0; exp_ptr[k] = 0;
      frames[k] = 0; done_cnt[k] = 0; abort_cnt[k] = 0; pop_cnt[k] = 0;
    end

    check(build_frame(8'h55, 0) == 12'hEAA, "model_55", build_frame(8'h55, 0), 12'hEAA);
    check(build_frame(8'h07, 2) == 12'hE0E, "model_07_even", build_frame(8'h07, 2), 12'hE0E);
    check(build_frame(8'h07, 1) == 12'hC0E, "model_07_odd", build_frame(8'h07, 1), 12'hC0E);

    repeat (3) tick();
    check(tx[0] == 1'b1, "reset_tx", tx[0], 1);
    check(fifo_pop[0] == 1'b0, "reset_pop", fifo_pop[0], 0);
    check(busy[0] == 1'b0, "reset_busy", busy[0], 0);
    check(done[0] == 1'b0, "reset_done", done[0], 0);
    check(aborted[0] == 1'b0, "reset_aborted", aborted[0], 0);
    check(byte_count[0] == 16'd0, "reset_count", byte_count[0], 0);
    clear_n = 1'b1;
    repeat (4) tick();

    // Single byte, plus a start pulse mid-frame that must be ignored.
    push(0, 8'h55);
    f0 = frames[0]; d0 = done_cnt[0]; p0 = pop_cnt[0];
    pulse(0);
    check(busy[0] == 1'b1, "t1_busy", busy[0], 1);
    wait_sig(0, 2, 50, "t1_start_bit", n);
    repeat (1000) tick();
    pulse(0);
    wait_sig(0, 0, 6000, "t1_done", n);
    check(byte_count[0] == 16'd1, "t1_count", byte_count[0], 1);
    check(frames[0] - f0 == 1, "t1_frames", frames[0] - f0, 1);
    check(pop_cnt[0] - p0 == 2, "t1_pops", pop_cnt[0] - p0, 2);
    tick();
    check(busy[0] == 1'b0, "t1_idle", busy[0], 0);
    check(done_cnt[0] - d0 == 1, "t1_single_done", done_cnt[0] - d0, 1);

    // Empty fifo: one pop, no frame, quick done.
    f0 = frames[0]; p0 = pop_cnt[0];
    pulse(0);
    wait_sig(0, 0, 20, "t2_done", n);
    check(n <= 6, "t2_done_latency", n, 6);
    check(byte_count[0] == 16'd0, "t2_count", byte_count[0], 0);
    check(pop_cnt[0] - p0 == 1, "t2_pops", pop_cnt[0] - p0, 1);
    check(frames[0] - f0 == 0, "t2_frames", frames[0] - f0, 0);
    repeat (3) tick();

    // Three bytes back to back.
    push(0, 8'hA5); push(0, 8'h0F); push(0, 8'hFF);
    f0 = frames[0]; d0 = done_cnt[0];
    pulse(0);
    wait_sig(0, 0, 3 * 10 * DIV + 200, "t3_done", n);
    check(byte_count[0] == 16'd3, "t3_count", byte_count[0], 3);
    check(frames[0] - f0 == 3, "t3_frames", frames[0] - f0, 3);
    tick();
    check(done_cnt[0] - d0 == 1, "t3_single_done", done_cnt[0] - d0, 1);
    check(exp_ptr[0] == wr_ptr[0], "t3_all_sent", wr_ptr[0] - exp_ptr[0], 0);

    // Reset mid data bit, then the next byte goes out cleanly.
    push(0, 8'h3C); push(0, 8'h81);
    pulse(0);
    wait_sig(0, 2, 50, "t4_start_bit", n);
    repeat (DIV + 200) tick();
    clear_n = 1'b0;
    #1;
    check(tx[0] == 1'b1, "t4_reset_tx", tx[0], 1);
    check(busy[0] == 1'b0, "t4_reset_busy", busy[0], 0);
    check(fifo_pop[0] == 1'b0, "t4_reset_pop", fifo_pop[0], 0);
    check(byte_count[0] == 16'd0, "t4_reset_count", byte_count[0], 0);
    repeat (2) tick();
    clear_n = 1'b1;
    repeat (3) tick();
    f0 = frames[0];
    pulse(0);
    wait_sig(0, 0, 6000, "t4_done", n);
    check(byte_count[0] == 16'd1, "t4_count", byte_count[0], 1);
    check(frames[0] - f0 == 1, "t4_frames", frames[0] - f0, 1);
    check(exp_ptr[0] == wr_ptr[0], "t4_next_byte_sent", wr_ptr[0] - exp_ptr[0], 0);
    repeat (3) tick();

    // fifo_ready lost during frame 1: frame completes, abort, no further pop.
    push(0, 8'h12); push(0, 8'h34);
    f0 = frames[0]; d0 = done_cnt[0]; p0 = pop_cnt[0]; a0 = abort_cnt[0];
    pulse(0);
    wait_sig(0, 2, 50, "t5_start_bit", n);
    repeat (2 * DIV + 30) tick();
    fifo_ready[0] = 1'b0;
    wait_sig(0, 1, 10 * DIV, "t5_aborted", n);
    check(frames[0] - f0 == 1, "t5_frames", frames[0] - f0, 1);
    check(byte_count[0] == 16'd1, "t5_count", byte_count[0], 1);
    repeat (20) tick();
    check(pop_cnt[0] - p0 == 1, "t5_pops", pop_cnt[0] - p0, 1);
    check(done_cnt[0] - d0 == 0, "t5_no_done", done_cnt[0] - d0, 0);
    check(abort_cnt[0] - a0 == 1, "t5_abort_count", abort_cnt[0] - a0, 1);
    check(busy[0] == 1'b0, "t5_idle", busy[0], 0);
    check(wr_ptr[0] - exp_ptr[0] == 1, "t5_byte_left", wr_ptr[0] - exp_ptr[0], 1);
    pulse(0);
    check(aborted[0] == 1'b1, "t5_start_not_ready", aborted[0], 1);
    check(busy[0] == 1'b0, "t5_start_not_ready_busy", busy[0], 0);
    fifo_ready[0] = 1'b1;

    // Even parity with two stop bits.
    push(1, 8'h07);
    pulse(1);
    wait_sig(1, 0, 14 * DIV, "t6_done", n);
    check(byte_count[1] == 16'd1, "t6_count", byte_count[1], 1);
    check(frames[1] == 1, "t6_frames", frames[1], 1);

    // Odd parity, one stop bit.
    push(2, 8'h07);
    pulse(2);
    wait_sig(2, 0, 13 * DIV, "t7_done", n);
    check(byte_count[2] == 16'd1, "t7_count", byte_count[2], 1);
    check(frames[2] == 1, "t7_frames", frames[2], 1);

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
